// File: rtl/request_queue_arbiter.sv
// request_queue_arbiter: N-requester first-come-first-served arbiter.
// Waiting requesters sit in a shift-register FIFO of IDs. Same-cycle arrivals
// are ordered round-robin starting at rr_ptr. A queued requester that drops
// req is removed from the queue, and the grant passes on with no idle cycle.
// Optional feature macro: HOLD_TIMEOUT_EN. When it is defined, a holder is
// force-released after MAX_HOLD consecutive cycles if anyone is waiting.
module request_queue_arbiter #(
   parameter int  N        = 4,
   parameter int  MAX_HOLD = 16,
   localparam int IDW      = $clog2(N)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   grant,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id,
   output logic [IDW:0]   queue_count
);

   if (N < 2 || N > 16 || MAX_HOLD < 2) begin : g_param_chk
      $error("request_queue_arbiter: illegal N or MAX_HOLD");
   end

   logic [IDW-1:0] fifo [N];
   logic [N-1:0]   pending;
   logic [IDW-1:0] rr_ptr;

   logic [IDW-1:0] wq [N];
   logic [IDW-1:0] nq [N];
   logic [N-1:0]   arr, pend_d, grant_d;
   logic           keep, fire, pop, take_arr, has_arr, nv;
   logic [IDW-1:0] nh;
   int             wcnt, ncnt, first_id;

`ifdef HOLD_TIMEOUT_EN
   localparam int HCW = $clog2(MAX_HOLD + 1);
   // hold_cnt = cycles the current holder has been visible, including this one
   logic [HCW-1:0] hold_cnt;

   // count consecutive cycles of one holder; saturates at MAX_HOLD
   always_ff @(posedge clock) begin
      if (!reset)                         hold_cnt <= '0;
      else if (!nv)                       hold_cnt <= '0;
      else if (!keep)                     hold_cnt <= HCW'(1);
      else if (hold_cnt != HCW'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
   end
`endif

   // next queue contents, next holder and next pending map
   always_comb begin
      int id;
      id       = 0;
      arr      = req & ~pending;
      wcnt     = 0;
      ncnt     = 0;
      first_id = 0;
      has_arr  = 1'b0;
      pend_d   = '0;
      for (int i = 0; i < N; i++) begin
         wq[i] = '0;
         nq[i] = '0;
      end

      // withdrawals: compact the queue, keeping relative order
      for (int i = 0; i < N; i++)
         if (i < int'(queue_count) && req[fifo[i]]) begin
            wq[wcnt] = fifo[i];
            wcnt     = wcnt + 1;
         end

      // first new arrival in rotated order
      for (int k = 0; k < N; k++) begin
         id = (int'(rr_ptr) + k) % N;
         if (arr[id] && !has_arr) begin
            has_arr  = 1'b1;
            first_id = id;
         end
      end

`ifdef HOLD_TIMEOUT_EN
      fire = grant_valid && req[grant_id] && (hold_cnt == HCW'(MAX_HOLD)) && (wcnt > 0);
`else
      fire = 1'b0;
`endif
      keep     = grant_valid && req[grant_id] && !fire;
      pop      = !keep && (wcnt > 0);
      take_arr = !keep && !pop && has_arr;
      nv       = keep || pop || take_arr;
      nh       = keep ? grant_id : pop ? wq[0] : take_arr ? IDW'(first_id) : '0;

      // survivors (minus popped head), then arrivals, then a timed-out holder
      for (int i = 0; i < N; i++)
         if (i >= (pop ? 1 : 0) && i < wcnt) begin
            nq[ncnt] = wq[i];
            ncnt     = ncnt + 1;
         end
      for (int k = 0; k < N; k++) begin
         id = (int'(rr_ptr) + k) % N;
         if (arr[id] && !(take_arr && id == first_id)) begin
            nq[ncnt] = IDW'(id);
            ncnt     = ncnt + 1;
         end
      end
      if (fire) begin
         nq[ncnt] = grant_id;
         ncnt     = ncnt + 1;
      end

      for (int i = 0; i < N; i++)
         if (i < ncnt) pend_d[nq[i]] = 1'b1;
      if (nv) pend_d[nh] = 1'b1;

      grant_d = nv ? (N'(1) << nh) : '0;
   end

   // state and registered outputs; reset wins over everything
   always_ff @(posedge clock) begin
      if (!reset) begin
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         queue_count <= '0;
         pending     <= '0;
         rr_ptr      <= '0;
         for (int i = 0; i < N; i++) fifo[i] <= '0;
      end else begin
         grant       <= grant_d;
         grant_valid <= nv;
         grant_id    <= nh;
         queue_count <= ncnt[IDW:0];
         pending     <= pend_d;
         for (int i = 0; i < N; i++) fifo[i] <= nq[i];
         if (nv && !keep) rr_ptr <= IDW'((int'(nh) + 1) % N);
      end
   end

endmodule

// File: tb/tb_request_queue_arbiter.sv
// Self-checking bench for request_queue_arbiter (N=4, MAX_HOLD=4).
// Expected grant order is queued per scenario; a monitor logs each new grant.
module tb_request_queue_arbiter;
   localparam int N = 4;

   logic         clock = 1'b0;
   logic         reset;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic [1:0]   grant_id;
   logic [2:0]   queue_count;

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_q[$];
   logic [1:0] obs_q[$];
   logic       started = 1'b0;
   logic       prev_v  = 1'b0;
   logic [1:0] prev_id = '0;

   request_queue_arbiter #(.N(N), .MAX_HOLD(4)) dut (
      .clock(clock), .reset(reset), .req(req), .grant(grant),
      .grant_valid(grant_valid), .grant_id(grant_id), .queue_count(queue_count)
   );

   always #5 clock = ~clock;

   // log each new grant and check output consistency
   always @(negedge clock) begin
      if (started) begin
         if (grant_valid && (!prev_v || grant_id != prev_id)) obs_q.push_back(grant_id);
         checks++;
         if (!$onehot0(grant) || grant_valid !== (|grant) ||
             (grant_valid && grant !== (4'b0001 << grant_id)) || (!grant_valid && grant_id !== 2'd0)) begin
            errors++;
            $display("FAIL invariant: grant=%b valid=%b id=%0d", grant, grant_valid, grant_id);
         end
      end
      prev_v  <= grant_valid;
      prev_id <= grant_id;
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      req   = '0;
      tick();
      reset = 1'b1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset;
      logic [1:0] e, o;
      reset = 1'b0;
      req   = 4'b1111;
      tick();
      tick();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
      checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", grant_id); end
      checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_qc: got %0d want 0", queue_count); end
      started = 1'b1;
      exp_q.delete(); obs_q.delete();
      exp_q.push_back(2'd0);
      reset = 1'b1;
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
      checks++; if (queue_count !== 3'd3) begin errors++; $display("FAIL reset_first_qc: got %0d want 3", queue_count); end
      req = '0;
      tick();
      checks++; if (grant_valid !== 1'b0 || queue_count !== 3'd0) begin
         errors++; $display("FAIL reset_drain: got valid=%b qc=%0d want 0/0", grant_valid, queue_count); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL reset_order: got none want %0d", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL reset_order: got %0d want %0d", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_order: %0d extra grants", obs_q.size()); end
   endtask

   task automatic test_fcfs;
      logic [1:0] e, o;
      do_reset();
      exp_q.push_back(2'd2); exp_q.push_back(2'd0); exp_q.push_back(2'd3);
      req = 4'b0100; tick();
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL fcfs_first: got %b want 0100", grant); end
      req = 4'b0101; tick();
      req = 4'b1101; tick();
      checks++; if (queue_count !== 3'd2) begin errors++; $display("FAIL fcfs_qc: got %0d want 2", queue_count); end
      req = 4'b1001; tick();
      checks++; if (grant !== 4'b0001 || queue_count !== 3'd1) begin
         errors++; $display("FAIL fcfs_handoff0: got %b qc=%0d want 0001 qc=1", grant, queue_count); end
      req = 4'b1000; tick();
      checks++; if (grant !== 4'b1000 || queue_count !== 3'd0) begin
         errors++; $display("FAIL fcfs_handoff3: got %b qc=%0d want 1000 qc=0", grant, queue_count); end
      req = 4'b0000; tick();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL fcfs_idle: got %b want 0000", grant); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL fcfs_order: got none want %0d", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL fcfs_order: got %0d want %0d", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL fcfs_order: %0d extra grants", obs_q.size()); end
   endtask

   task automatic test_rr_tie;
      logic [1:0] e, o;
      do_reset();
      exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
      req = 4'b0010; tick();
      req = 4'b0000; tick();
      req = 4'b1101; tick();
      checks++; if (grant !== 4'b0100 || queue_count !== 3'd2) begin
         errors++; $display("FAIL rr_tie_first: got %b qc=%0d want 0100 qc=2", grant, queue_count); end
      req = 4'b1001; tick();
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL rr_tie_second: got %b want 1000", grant); end
      req = 4'b0001; tick();
      req = 4'b0000; tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL rr_order: got none want %0d", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rr_order: got %0d want %0d", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rr_order: %0d extra grants", obs_q.size()); end
   endtask

   task automatic test_withdraw;
      logic [1:0] e, o;
      do_reset();
      exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd2);
      req = 4'b1010; tick();
      checks++; if (grant !== 4'b0010 || queue_count !== 3'd1) begin
         errors++; $display("FAIL wd_setup: got %b qc=%0d want 0010 qc=1", grant, queue_count); end
      req = 4'b1011; tick();
      req = 4'b1111; tick();
      checks++; if (queue_count !== 3'd3) begin errors++; $display("FAIL wd_full: got %0d want 3", queue_count); end
      req = 4'b1110; tick();
      checks++; if (queue_count !== 3'd2 || grant !== 4'b0010) begin
         errors++; $display("FAIL wd_remove: got qc=%0d %b want qc=2 0010", queue_count, grant); end
      req = 4'b1100; tick();
      checks++; if (grant !== 4'b1000 || queue_count !== 3'd1) begin
         errors++; $display("FAIL wd_release: got %b qc=%0d want 1000 qc=1", grant, queue_count); end
      req = 4'b0100; tick();
      req = 4'b0000; tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL wd_order: got none want %0d", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL wd_order: got %0d want %0d", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL wd_order: %0d extra grants", obs_q.size()); end
   endtask

   task automatic test_reset_mid;
      logic [1:0] e, o;
      do_reset();
      exp_q.push_back(2'd1); exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
      req = 4'b0010; tick();
      req = 4'b0111; tick();
      checks++; if (grant !== 4'b0010 || queue_count !== 3'd2) begin
         errors++; $display("FAIL mid_setup: got %b qc=%0d want 0010 qc=2", grant, queue_count); end
      reset = 1'b0; tick();
      checks++; if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0 || queue_count !== 3'd0) begin
         errors++; $display("FAIL mid_reset: got %b v=%b id=%0d qc=%0d want all zero", grant, grant_valid, grant_id, queue_count); end
      reset = 1'b1; tick();
      checks++; if (grant !== 4'b0001 || queue_count !== 3'd2) begin
         errors++; $display("FAIL mid_rearb: got %b qc=%0d want 0001 qc=2", grant, queue_count); end
      req = 4'b0110; tick();
      req = 4'b0100; tick();
      req = 4'b0000; tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL mid_order: got none want %0d", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL mid_order: got %0d want %0d", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_order: %0d extra grants", obs_q.size()); end
   endtask

   task automatic test_rerequest;
      logic [1:0] e, o;
      do_reset();
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
      req = 4'b0001; tick();
      req = 4'b0011; tick();
      req = 4'b0010; tick();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rereq_handoff: got %b want 0010", grant); end
      req = 4'b0011; tick();
      checks++; if (queue_count !== 3'd1 || grant !== 4'b0010) begin
         errors++; $display("FAIL rereq_tail: got %b qc=%0d want 0010 qc=1", grant, queue_count); end
      req = 4'b0001; tick();
      req = 4'b0000; tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL rereq_order: got none want %0d", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rereq_order: got %0d want %0d", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rereq_order: %0d extra grants", obs_q.size()); end
   endtask

   task automatic test_hold;
      logic [1:0] e, o;
      do_reset();
`ifdef HOLD_TIMEOUT_EN
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
      req = 4'b0001; tick();
      req = 4'b0011; tick(); tick(); tick();
      checks++; if (grant !== 4'b0001 || queue_count !== 3'd1) begin
         errors++; $display("FAIL hold_first4: got %b qc=%0d want 0001 qc=1", grant, queue_count); end
      tick();
      checks++; if (grant !== 4'b0010 || queue_count !== 3'd1) begin
         errors++; $display("FAIL hold_switch1: got %b qc=%0d want 0010 qc=1", grant, queue_count); end
      tick(); tick(); tick();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL hold_keep1: got %b want 0010", grant); end
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL hold_switch0: got %b want 0001", grant); end
`else
      exp_q.push_back(2'd0);
      req = 4'b0011; tick();
      checks++; if (grant !== 4'b0001 || queue_count !== 3'd1) begin
         errors++; $display("FAIL hold_first: got %b qc=%0d want 0001 qc=1", grant, queue_count); end
      repeat (10) tick();
      checks++; if (grant !== 4'b0001 || queue_count !== 3'd1) begin
         errors++; $display("FAIL hold_keep: got %b qc=%0d want 0001 qc=1", grant, queue_count); end
`endif
      req = 4'b0000; tick();
      checks++; if (grant_valid !== 1'b0 || queue_count !== 3'd0) begin
         errors++; $display("FAIL hold_drain: got v=%b qc=%0d want 0/0", grant_valid, queue_count); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL hold_order: got none want %0d", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL hold_order: got %0d want %0d", o, e); end end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL hold_order: %0d extra grants", obs_q.size()); end
   endtask

   initial begin
      reset = 1'b0;
      req   = '0;
      test_reset();
      test_fcfs();
      test_rr_tie();
      test_withdraw();
      test_reset_mid();
      test_rerequest();
      test_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
